// File: rtl/booth_pkg.sv
// Shared constants and FSM encoding for the Booth multiplier accumulator back end.
package booth_pkg;

   localparam int N     = 8;
   localparam int P_W   = 2 * N;
   localparam int ACC_W = 24;
   localparam int LEN_W = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

endpackage

// File: rtl/booth_acc_add.sv
// Combinational sign-extend, add and overflow detect for the accumulator.
// Define BOOTH_ACC_SATURATE_EN to clamp on overflow instead of wrapping.
module booth_acc_add
   import booth_pkg::*;
#(
   parameter int P_W   = booth_pkg::P_W,
   parameter int ACC_W = booth_pkg::ACC_W
) (
   input  logic [ACC_W-1:0] acc_i,
   input  logic [P_W-1:0]   p_i,
   output logic [ACC_W-1:0] sum_o,
   output logic             ovf_o
);

   logic signed [ACC_W-1:0] a_s;
   logic signed [ACC_W-1:0] b_s;
   logic signed [ACC_W:0]   s_s;

   assign a_s = $signed(acc_i);
   assign b_s = ACC_W'($signed(p_i));
   assign s_s = {a_s[ACC_W-1], a_s} + {b_s[ACC_W-1], b_s};

   // With one guard bit, the top two sum bits disagree exactly when two
   // equal-signed operands produced a result of the opposite sign.
   assign ovf_o = s_s[ACC_W] ^ s_s[ACC_W-1];

`ifdef BOOTH_ACC_SATURATE_EN
   always_comb begin
      sum_o = s_s[ACC_W-1:0];
      if (ovf_o) begin
         // The guard bit carries the true sign, giving the clamp direction.
         sum_o = s_s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end
   end
`else
   assign sum_o = s_s[ACC_W-1:0];
`endif

endmodule

// File: rtl/booth_acc.sv
// Streaming signed accumulator behind the Booth multiplier: sums len products per job.
// Overflow response is wrap by default; BOOTH_ACC_SATURATE_EN selects saturation.
module booth_acc
   import booth_pkg::*;
#(
   parameter int N     = booth_pkg::N,
   parameter int P_W   = 2 * N,
   parameter int ACC_W = booth_pkg::ACC_W,
   parameter int LEN_W = booth_pkg::LEN_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [P_W-1:0]   in_p,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_acc,
   output logic             out_ovf,
   output logic             busy
);

   state_t             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [LEN_W-1:0]   rem_q, rem_d;
   logic               ovf_q, ovf_d;
   logic [ACC_W-1:0]   add_sum;
   logic               add_ovf;

   booth_acc_add #(
      .P_W   (P_W),
      .ACC_W (ACC_W)
   ) u_add (
      .acc_i (acc_q),
      .p_i   (in_p),
      .sum_o (add_sum),
      .ovf_o (add_ovf)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         rem_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         rem_q   <= rem_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      rem_d     = rem_q;
      ovf_d     = ovf_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               acc_d   = '0;
               ovf_d   = 1'b0;
               rem_d   = len;
               state_d = (len == '0) ? DONE : ACC;
            end
         end
         ACC: begin
            in_ready = 1'b1;
            if (in_valid) begin
               acc_d = add_sum;
               ovf_d = ovf_q | add_ovf;
               rem_d = rem_q - LEN_W'(1);
               if (rem_q == LEN_W'(1)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            // Result is held in acc_q/ovf_q until the consumer takes it.
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign out_acc = acc_q;
   assign out_ovf = ovf_q;
   assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_booth_acc.sv
// Scoreboard bench for booth_acc: directed jobs push expected results, a monitor checks them.
module tb_booth_acc;

   localparam int P_W   = 16;
   localparam int ACC_W = 24;
   localparam int LEN_W = 10;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [LEN_W-1:0] len = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [P_W-1:0]   in_p = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [ACC_W-1:0] out_acc;
   logic             out_ovf;
   logic             busy;

   typedef struct {
      logic signed [63:0] acc;
      logic               ovf;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;

   booth_acc dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .len       (len),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_p      (in_p),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_acc   (out_acc),
      .out_ovf   (out_ovf),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   // Monitor: every accepted result is compared against the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_result", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("out_acc", $signed(out_acc), e.acc);
            chk("out_ovf", {63'd0, out_ovf}, {63'd0, e.ovf});
         end
      end
   end

   task automatic push_exp(input logic signed [63:0] a, input logic o);
      exp_t e;
      e.acc = a;
      e.ovf = o;
      exp_q.push_back(e);
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (busy && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (busy) chk("idle_timeout", 1, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input int l);
      start = 1'b1;
      len   = LEN_W'(l);
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic send_beat(input int p, input int gap);
      int n = 0;
      in_valid = 1'b1;
      in_p     = P_W'(p);
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("in_ready_timeout", 1, 0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      // Reset state
      #12;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_acc", $signed(out_acc), 0);
      chk("rst_out_ovf", out_ovf, 0);
      chk("rst_busy", busy, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic sum: 100 - 50 + 32767 - 32768 = 49
      push_exp(49, 1'b0);
      start_job(4);
      send_beat(100, 0);
      send_beat(-50, 0);
      send_beat(32767, 0);
      send_beat(-32768, 0);
      chk("basic_latency_valid", out_valid, 1);
      wait_idle();

      // Zero length goes straight to DONE and never opens the input
      out_ready = 1'b0;
      start_job(0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("zero_out_valid", out_valid, 1);
         chk("zero_in_ready", in_ready, 0);
         chk("zero_out_acc", $signed(out_acc), 0);
      end
      push_exp(0, 1'b0);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      wait_idle();

      // Gaps between beats and output backpressure with stray start pulses
      push_exp(24, 1'b0);
      out_ready = 1'b0;
      start_job(3);
      send_beat(7, 2);
      send_beat(8, 2);
      send_beat(9, 0);
      start = 1'b1;
      len   = LEN_W'(5);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_out_valid", out_valid, 1);
         chk("bp_out_acc", $signed(out_acc), 24);
      end
      @(posedge clk);
      #1;
      start     = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_idle_busy", busy, 0);
      chk("bp_idle_out_valid", out_valid, 0);
      @(negedge clk);
      chk("bp_start_ignored", busy, 0);

      // Overflow: 257 * 32767 = 8421119 exceeds +8388607
`ifdef BOOTH_ACC_SATURATE_EN
      push_exp(8388607, 1'b1);
`else
      push_exp(-8356097, 1'b1);
`endif
      @(posedge clk);
      #1;
      start_job(257);
      for (int i = 0; i < 257; i++) send_beat(32767, 0);
      wait_idle();

      // 256 * 32767 = 8388352 fits
      push_exp(8388352, 1'b0);
      start_job(256);
      for (int i = 0; i < 256; i++) send_beat(32767, 0);
      wait_idle();

      // Reset mid-job discards everything
      start_job(10);
      send_beat(1000, 0);
      send_beat(2000, 0);
      send_beat(3000, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready", in_ready, 0);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_out_acc", $signed(out_acc), 0);
      chk("mid_rst_out_ovf", out_ovf, 0);
      chk("mid_rst_busy", busy, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      push_exp(-11, 1'b0);
      start_job(2);
      send_beat(-5, 0);
      send_beat(-6, 0);
      wait_idle();

      repeat (3) @(posedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1);
   end

endmodule

// File: doc/booth_acc.md
Name: booth_acc

Overview:
- Sequential accumulator directly downstream of the combinational signed Booth multiplier (n=8, 16-bit product).
- Takes a stream of signed 16-bit products over a valid/ready handshake and sums a programmed number of them into a wide accumulator.
- Presents the result, with an overflow flag, on an output valid/ready handshake.
- Forms the MAC back end for dot-product and FIR use of the multiplier.

Parameters:
- N, 8, multiplier operand width.
- P_W, 2*N, product width fed in.
- ACC_W, 24, accumulator width; must be >= P_W.
- LEN_W, 10, width of the beat-count field.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a new accumulation; honoured only in IDLE.
- len  input  LEN_W  number of products to accumulate; sampled with start.
- in_valid  input  1  product beat valid.
- in_ready  output  1  block accepts a product this cycle.
- in_p  input  P_W  signed product from multiplier.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes result.
- out_acc  output  ACC_W  signed accumulated sum.
- out_ovf  output  1  sticky: at least one signed add overflowed ACC_W.
- busy  output  1  high in ACC or DONE.

Behaviour:
- Clock/reset: one clock, clk. Reset is asynchronous and active-low on rst_n, named rst_n.
- Reset values: state=IDLE, acc=0, remaining=0, ovf=0. Outputs in_ready=0, out_valid=0, out_acc=0, out_ovf=0, busy=0.
- Asserting rst_n low mid-operation aborts immediately; any partial sum is discarded.
- FSM states: IDLE, ACC, DONE.
- IDLE:
  - in_ready=0, out_valid=0.
  - On start: acc<=0, ovf<=0, remaining<=len.
  - If len!=0, go to ACC; if len==0, go directly to DONE with acc=0.
- ACC:
  - in_ready=1.
  - On each cycle with in_valid&in_ready: acc<=acc+sign_extend(in_p) and remaining<=remaining-1.
  - When the accepted beat has remaining==1, go to DONE.
  - in_valid low: hold state, no change.
- DONE:
  - in_ready=0, out_valid=1.
  - out_acc and out_ovf are held stable until out_ready=1; then go to IDLE on the next edge.
  - out_acc retains its last value in IDLE; out_valid drops.
- start is ignored outside IDLE, including the DONE cycle in which out_ready is high. A new job therefore needs start in a cycle where state==IDLE.
- Latency: out_valid rises on the edge after the last accepted beat. Throughput is one product per cycle in ACC.
- Arithmetic:
  - in_p is sign-extended from P_W to ACC_W.
  - The sum is computed at ACC_W+1 bits.
  - Overflow is detected when the two operand signs are equal and differ from the result sign; this sets ovf (sticky for the job).
- Default overflow response is two's-complement wrap.
- Maximum len is 2^LEN_W-1; len is unsigned.

Optional Feature:
- Macro: BOOTH_ACC_SATURATE_EN.
- Defined: on overflow, acc clamps to +(2^(ACC_W-1)-1) for positive overflow or -(2^(ACC_W-1)) for negative overflow. Further adds continue from the clamped value; ovf is still set.
- Undefined: acc wraps modulo 2^ACC_W; ovf set as above.
- Handshake and timing are identical either way.

Decomposition:
- Shared package booth_pkg: N, P_W, ACC_W, LEN_W defaults; FSM state enum (IDLE=0, ACC=1, DONE=2); ACC_MAX and ACC_MIN constants.
- One natural sub-module: booth_acc_add, the combinational sign-extend, add, overflow and optional saturate; instantiated once.
- FSM and registers stay in booth_acc.

Test Plan:
- Basic sum: start with len=4; beats 100, -50, 32767, -32768, all back-to-back -> out_valid one cycle after 4th beat, out_acc=49, out_ovf=0.
- Zero length: start with len=0 -> DONE next cycle, out_acc=0, in_ready never high, out_valid until out_ready.
- Gaps and backpressure: len=3 beats 7, 8, 9 with in_valid low 2 cycles between beats; out_ready low 5 cycles -> out_acc=24 stable all 5 cycles, start pulses during DONE ignored, IDLE after out_ready.
- Overflow with len=257, all beats 32767:
  - Wrap build -> out_acc=-8356097, out_ovf=1.
  - BOOTH_ACC_SATURATE_EN build -> out_acc=8388607, out_ovf=1.
  - len=256 -> out_acc=8388352, out_ovf=0.
- Reset mid-job: len=10, rst_n low after 3 beats -> all outputs 0 asynchronously. A new job with len=2, beats -5, -6 -> out_acc=-11.
